alu_result_stage: RTL

Registered result stage directly downstream of the ALU in the execute path. It captures the ALU result (`z`, `equal`, `zero`, `overflow`) together with the operation's funct code and destination register tag, and buffers them in a 2-entry in-order skid buffer. The buffer sits behind a valid/ready handshake toward the memory/writeback side. It also counts signed-arithmetic overflows and, optionally, raises a sticky overflow trap.

---
 rtl/alu_result_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result stage behind the ALU. It captures the result fields
// (z, equal, zero, overflow), the funct code and the destination register
// tag into a 2-entry in-order skid buffer with a valid/ready handshake on
// both sides. It also keeps a saturating count of ADD/SUB overflows.
//
// Optional feature (macro ALU_OVF_TRAP_EN): a counted overflow push sets a
// sticky trap that blocks further pushes until trap_clr is asserted.
// Without the macro, trap is tied low and trap_clr is ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   in_z, in_equal, in_zero,    ALU result fields, funct code, rd tag
//   in_overflow, in_funct, in_rd
//   out_valid / out_ready       downstream handshake
//   out_z ... out_rd            head entry (hold last value when empty)
//   ovf_count                   saturating count of accepted ADD/SUB overflows
//   trap, trap_clr              sticky overflow trap and its clear

`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ALU_FUNCT_ADD
`define ALU_FUNCT_ADD 4'd0
`endif
`ifndef ALU_FUNCT_SUB
`define ALU_FUNCT_SUB 4'd1
`endif

module alu_result_stage #(
    parameter int N       = 32,
    parameter int FUNCT_W = `ALU_FUNCT_WIDTH,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_z,
    input  logic               in_equal,
    input  logic               in_zero,
    input  logic               in_overflow,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [RD_W-1:0]    in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_z,
    output logic               out_equal,
    output logic               out_zero,
    output logic               out_overflow,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [RD_W-1:0]    out_rd,
    output logic [7:0]         ovf_count,
    output logic               trap,
    input  logic               trap_clr
);

    // Entry layout: {z, equal, zero, overflow, funct, rd}
    localparam int E_W = N + 3 + FUNCT_W + RD_W;

    logic [E_W-1:0] head_r;
    logic [E_W-1:0] tail_r;
    logic [E_W-1:0] in_entry_s;
    logic [1:0]     count_r;
    logic [7:0]     ovf_count_r;
    logic           trap_s;
    logic           push_s;
    logic           pop_s;
    logic           counted_ovf_s;

    // Ready depends only on registered occupancy and trap state.
    assign in_ready  = (count_r != 2'd2) && !trap_s;
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    assign counted_ovf_s = push_s && in_overflow &&
                           ((in_funct == FUNCT_W'(`ALU_FUNCT_ADD)) ||
                            (in_funct == FUNCT_W'(`ALU_FUNCT_SUB)));

    // Build the entry to store; writes to x0 read back as zero.
    always_comb begin
        in_entry_s = {E_W{1'b0}};
        if (in_rd == {RD_W{1'b0}}) begin
            in_entry_s = {{N{1'b0}}, in_equal, 1'b1, in_overflow, in_funct, in_rd};
        end else begin
            in_entry_s = {in_z, in_equal, in_zero, in_overflow, in_funct, in_rd};
        end
    end

    // Two-slot shift buffer: head_r is always the oldest entry, and it keeps
    // its contents after the last pop so out_* hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= {E_W{1'b0}};
            tail_r  <= {E_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= in_entry_s;
                    end else begin
                        tail_r <= in_entry_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1 (full blocks push).
                    if (count_r == 2'd1) begin
                        head_r <= in_entry_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_entry_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Saturating overflow counter for ADD/SUB pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_r <= 8'd0;
        end else if (counted_ovf_s && (ovf_count_r != 8'hFF)) begin
            ovf_count_r <= ovf_count_r + 8'd1;
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic trap_r;

    // Sticky trap; a clear wins, and no push can land while trapped anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else if (trap_clr) begin
            trap_r <= 1'b0;
        end else if (counted_ovf_s) begin
            trap_r <= 1'b1;
        end
    end

    assign trap_s = trap_r;
`else
    logic trap_clr_unused_s;

    assign trap_clr_unused_s = trap_clr;
    assign trap_s            = 1'b0;
`endif

    assign trap         = trap_s;
    assign ovf_count    = ovf_count_r;
    assign out_z        = head_r[E_W-1 -: N];
    assign out_equal    = head_r[FUNCT_W + RD_W + 2];
    assign out_zero     = head_r[FUNCT_W + RD_W + 1];
    assign out_overflow = head_r[FUNCT_W + RD_W];
    assign out_funct    = head_r[RD_W +: FUNCT_W];
    assign out_rd       = head_r[RD_W-1:0];

endmodule
